// File: rtl/instr_fifo_pkg.sv
// rtl/instr_fifo_pkg.sv - shared types, constants and helpers for the instr_fifo write side
package instr_fifo_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int BEAT_CNT_W = 16;

    // Next round-robin pointer, wrapping modulo n (n is at most 8).
    function automatic logic [2:0] rr_next(input logic [2:0] ptr, input int n);
        if (int'(ptr) >= n - 1) begin
            return 3'd0;
        end
        return ptr + 3'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority encoder
// Ports:
//   i_req     [NUM_REQ]  request vector
//   i_ptr     [ID_W]     highest-priority index this cycle
//   o_gnt_idx [ID_W]     first requester at or after i_ptr, wrapping
//   o_any                at least one request is set
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [ID_W-1:0]    o_gnt_idx,
    output logic               o_any
);
    import instr_fifo_pkg::*;

    localparam logic [ID_W:0] NREQ_W = (ID_W + 1)'(NUM_REQ);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest requester to
    // i_ptr is the last assignment and therefore wins.
    always_comb begin
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (ID_W + 1)'(k);
            if (w_sum >= NREQ_W) begin
                w_sum = w_sum - NREQ_W;
            end
            w_idx = w_sum[ID_W-1:0];
            if (i_req[w_idx]) begin
                o_gnt_idx = w_idx;
                o_any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fifo_wr_arb.sv
// rtl/instr_fifo_wr_arb.sv - round-robin burst arbiter for the instr_fifo write port
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_req_valid/last [NUM_REQ]    per-producer stream valid / last beat
//   i_req_data [NUM_REQ*DW]       producer i at [i*DW +: DW]
//   o_req_ready [NUM_REQ]         per-producer accept strobe
//   i_fifo_full/empty/rr          FIFO status and observed consumer read
//   o_fifo_din, o_fifo_wr         FIFO write data and strobe
//   o_grant_id, o_busy            current owner, burst grant held
//   o_beat_cnt                    saturating count of accepted beats
module instr_fifo_wr_arb
    import instr_fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_fifo_full,
    input  logic                          i_fifo_empty,
    input  logic                          i_fifo_rr,
    output logic [DATA_WIDTH-1:0]         o_fifo_din,
    output logic                          o_fifo_wr,
    output logic [ID_W-1:0]               o_grant_id,
    output logic                          o_busy,
    output logic [BEAT_CNT_W-1:0]         o_beat_cnt
);

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [ID_W-1:0]         r_grant_id;
    logic [ID_W-1:0]         r_rr_ptr;
    logic [3:0]              r_burst_cnt;
    logic [BEAT_CNT_W-1:0]   r_beat_cnt;

    logic [ID_W-1:0]         w_pick_idx;
    logic                    w_pick_any;
    logic                    w_busy;
    logic                    w_blk;
    logic                    w_own_valid;
    logic                    w_own_last;
    logic [DATA_WIDTH-1:0]   w_own_data;
    logic                    w_accept;
    logic                    w_release;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_req     (i_req_valid),
        .i_ptr     (r_rr_ptr),
        .o_gnt_idx (w_pick_idx),
        .o_any     (w_pick_any)
    );

    assign w_busy = (r_state == ARB_BURST);

    // A consumer read on a non-empty FIFO takes priority there and would
    // silently drop a simultaneous write, so hold the producer instead.
    assign w_blk = i_fifo_full | (i_fifo_rr & ~i_fifo_empty);

    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == ID_W'(i)) begin
                w_own_valid = i_req_valid[i];
                w_own_last  = i_req_last[i];
                w_own_data  = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_accept  = w_busy & ~w_blk & w_own_valid;
    assign w_release = w_accept & (w_own_last | (r_burst_cnt == BURST_LAST));

    // Ready depends only on registered grant and FIFO status, never on req_*.
    always_comb begin
        o_req_ready = '0;
        if (w_busy && !w_blk) begin
            o_req_ready[r_grant_id] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:  if (w_pick_any) w_state_nxt = ARB_BURST;
            ARB_BURST: if (w_release)  w_state_nxt = ARB_IDLE;
            default:   w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ARB_IDLE;
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_beat_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ARB_IDLE && w_pick_any) begin
                r_grant_id  <= w_pick_idx;
                r_burst_cnt <= '0;
            end
            if (w_accept) begin
                r_burst_cnt <= r_burst_cnt + 4'd1;
                if (r_beat_cnt != '1) begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end
            if (w_release) begin
                r_rr_ptr <= ID_W'(rr_next(3'(r_grant_id), NUM_REQ));
            end
        end
    end

    assign o_fifo_wr  = w_accept;
    assign o_fifo_din = w_busy ? w_own_data : '0;
    assign o_grant_id = r_grant_id;
    assign o_busy     = w_busy;
    assign o_beat_cnt = r_beat_cnt;

endmodule
